// File: rtl/troop_attacker.sv
// rtl/troop_attacker.sv - single-lane troop: deploy, march, strike tower, die
//
// Ports:
//   clk, reset        system clock; asynchronous active-high reset
//   gameClk           one-clk game tick enable (level counted every clk it is high)
//   spawn             deploy request, honoured only in IDLE
//   player            1 = player troop (511 -> 0), 0 = enemy troop (0 -> 511)
//   unitType[1:0]     troop class, latched at spawn
//   hitIn/damageIn    incoming hit strobe and its damage
//   targetDead        target tower already destroyed
//   position[8:0]     troop x-position
//   health[7:0]       troop health
//   damageOut[7:0]    damage per strike (to tower damageIn)
//   attackSCEN        one-clk strike strobe (to tower attackSCEN)
//   alive, dead       MARCH/ATTACK and DEAD indicators
module troop_attacker #(
  parameter logic [8:0] RANGE       = 9'd32,
  parameter logic [3:0] COOLDOWN    = 4'd8,
  parameter logic [3:0] DEATH_TICKS = 4'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gameClk,
  input  logic       spawn,
  input  logic       player,
  input  logic [1:0] unitType,
  input  logic       hitIn,
  input  logic [7:0] damageIn,
  input  logic       targetDead,
  output logic [8:0] position,
  output logic [7:0] health,
  output logic [7:0] damageOut,
  output logic       attackSCEN,
  output logic       alive,
  output logic       dead
);

  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_DEPLOY = 5'b00010;
  localparam logic [4:0] S_MARCH  = 5'b00100;
  localparam logic [4:0] S_ATTACK = 5'b01000;
  localparam logic [4:0] S_DEAD   = 5'b10000;

  logic [4:0] state_q, state_d;
  logic       player_q, player_d;
  logic [1:0] type_q, type_d;
  logic [8:0] pos_q, pos_d;
  logic [7:0] hp_q, hp_d;
  logic [7:0] dmg_q, dmg_d;
  logic [3:0] cd_q, cd_d;
  logic [3:0] tick_q, tick_d;

  logic [7:0] class_hp;
  logic [7:0] class_dmg;
  logic [1:0] class_speed;
  logic       in_fight;
  logic       lethal;
  logic       in_range;
  logic       strike;
  logic [9:0] fwd_sum;
  logic [8:0] step_pos;

  always_comb begin
    class_hp    = 8'd100;
    class_dmg   = 8'd10;
    class_speed = 2'd1;
    case (type_q)
      2'b00: begin class_hp = 8'd100; class_dmg = 8'd10; class_speed = 2'd1; end
      2'b01: begin class_hp = 8'd60;  class_dmg = 8'd20; class_speed = 2'd2; end
      2'b10: begin class_hp = 8'd200; class_dmg = 8'd5;  class_speed = 2'd1; end
      default: begin class_hp = 8'd40; class_dmg = 8'd40; class_speed = 2'd3; end
    endcase
  end

  assign in_fight = (state_q == S_MARCH) || (state_q == S_ATTACK);
  assign lethal   = in_fight && hitIn && (damageIn >= hp_q);
  assign in_range = player_q ? (pos_q <= RANGE) : (pos_q >= (9'd511 - RANGE));

  // Strike is combinational so it lasts exactly the gameClk cycle and
  // vanishes the moment reset clears the state register.
  assign strike = (state_q == S_ATTACK) && gameClk && (cd_q == 4'd0) && !targetDead;

  // One movement step toward the target, saturating at either lane end.
  assign fwd_sum  = {1'b0, pos_q} + {8'd0, class_speed};
  always_comb begin
    step_pos = pos_q;
    if (player_q) begin
      step_pos = (pos_q >= {7'd0, class_speed}) ? (pos_q - {7'd0, class_speed}) : 9'd0;
    end else begin
      step_pos = fwd_sum[9] ? 9'd511 : fwd_sum[8:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    type_d   = type_q;
    pos_d    = pos_q;
    hp_d     = hp_q;
    dmg_d    = dmg_q;
    cd_d     = cd_q;
    tick_d   = tick_q;
    case (state_q)
      S_IDLE: begin
        dmg_d = 8'd0;
        if (spawn) begin
          state_d  = S_DEPLOY;
          player_d = player;
          type_d   = unitType;
        end
      end
      S_DEPLOY: begin
        hp_d    = class_hp;
        dmg_d   = class_dmg;
        pos_d   = player_q ? 9'd511 : 9'd0;
        cd_d    = 4'd0;
        state_d = S_MARCH;
      end
      S_MARCH, S_ATTACK: begin
        if (hitIn) begin
          hp_d = lethal ? 8'd0 : (hp_q - damageIn);
        end
        // Priority: lethal hit, then tower gone, then normal behaviour.
        if (lethal) begin
          state_d = S_DEAD;
          tick_d  = 4'd0;
          dmg_d   = 8'd0;
        end else if (targetDead) begin
          state_d = S_IDLE;
          dmg_d   = 8'd0;
        end else if (state_q == S_MARCH) begin
          if (in_range) begin
            state_d = S_ATTACK;
          end else if (gameClk) begin
            pos_d = step_pos;
          end
        end else if (gameClk) begin
          cd_d = (cd_q == 4'd0) ? (COOLDOWN - 4'd1) : (cd_q - 4'd1);
        end
      end
      S_DEAD: begin
        hp_d  = 8'd0;
        dmg_d = 8'd0;
        if (gameClk) begin
          if (({1'b0, tick_q} + 5'd1) >= {1'b0, DEATH_TICKS}) begin
            state_d = S_IDLE;
            tick_d  = 4'd0;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      player_q <= 1'b0;
      type_q   <= 2'b00;
      pos_q    <= 9'd0;
      hp_q     <= 8'd0;
      dmg_q    <= 8'd0;
      cd_q     <= 4'd0;
      tick_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      type_q   <= type_d;
      pos_q    <= pos_d;
      hp_q     <= hp_d;
      dmg_q    <= dmg_d;
      cd_q     <= cd_d;
      tick_q   <= tick_d;
    end
  end

  assign position   = pos_q;
  assign health     = hp_q;
  assign damageOut  = dmg_q;
  assign attackSCEN = strike;
  assign alive      = in_fight;
  assign dead       = (state_q == S_DEAD);

endmodule

// File: tb/tb_troop_attacker.sv
// tb/tb_troop_attacker.sv - directed bench for troop_attacker
module tb_troop_attacker;

  logic       clk = 1'b0;
  logic       reset;
  logic       gameClk;
  logic       spawn;
  logic       player;
  logic [1:0] unitType;
  logic       hitIn;
  logic [7:0] damageIn;
  logic       targetDead;
  logic [8:0] position;
  logic [7:0] health;
  logic [7:0] damageOut;
  logic       attackSCEN;
  logic       alive;
  logic       dead;

  int vectors    = 0;
  int miscompares = 0;

  troop_attacker dut (
    .clk        (clk),
    .reset      (reset),
    .gameClk    (gameClk),
    .spawn      (spawn),
    .player     (player),
    .unitType   (unitType),
    .hitIn      (hitIn),
    .damageIn   (damageIn),
    .targetDead (targetDead),
    .position   (position),
    .health     (health),
    .damageOut  (damageOut),
    .attackSCEN (attackSCEN),
    .alive      (alive),
    .dead       (dead)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are read here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic spawn_troop(input logic p, input logic [1:0] t);
    spawn = 1'b1; player = p; unitType = t;
    cyc();
    spawn = 1'b0;
    cyc();
  endtask

  task automatic march_to(input logic [8:0] target, input int limit);
    int n;
    n = 0;
    gameClk = 1'b1;
    while (position !== target && n < limit) begin
      cyc();
      n++;
    end
    gameClk = 1'b0;
    chk("march_reach", position, target);
  endtask

  initial begin
    int exp_pos;
    reset = 1'b1; gameClk = 1'b0; spawn = 1'b0; player = 1'b0; unitType = 2'b00;
    hitIn = 1'b0; damageIn = 8'd0; targetDead = 1'b0;
    #1;
    chk("rst_position", position, 0);
    chk("rst_health", health, 0);
    chk("rst_damage", damageOut, 0);
    chk("rst_attack", attackSCEN, 0);
    chk("rst_alive", alive, 0);
    chk("rst_dead", dead, 0);
    cyc();
    reset = 1'b0;
    cyc();

    // Player class 01: deploy, march at -2 per tick every 4 clks.
    spawn = 1'b1; player = 1'b1; unitType = 2'b01;
    cyc();
    spawn = 1'b0;
    chk("deploy_alive", alive, 0);
    chk("deploy_pos_unloaded", position, 0);
    cyc();
    chk("march_pos0", position, 511);
    chk("march_hp", health, 60);
    chk("march_dmg", damageOut, 20);
    chk("march_alive", alive, 1);
    spawn = 1'b1;
    cyc();
    spawn = 1'b0;
    chk("spawn_in_march_pos", position, 511);
    exp_pos = 511;
    for (int k = 1; k <= 240; k++) begin
      gameClk = 1'b1;
      cyc();
      gameClk = 1'b0;
      exp_pos = exp_pos - 2;
      chk("march_step", position, exp_pos);
      cyc(); cyc(); cyc();
    end
    chk("range_stop_pos", position, 31);
    gameClk = 1'b1;
    #1;
    chk("first_strike", attackSCEN, 1);
    chk("first_strike_dmg", damageOut, 20);
    cyc();
    gameClk = 1'b0;
    #1;
    chk("strike_one_clk", attackSCEN, 0);
    chk("attack_pos_hold", position, 31);
    for (int t = 2; t <= 8; t++) begin
      cyc();
      gameClk = 1'b1;
      #1;
      chk("cooldown_quiet", attackSCEN, 0);
      cyc();
      gameClk = 1'b0;
    end
    gameClk = 1'b1; targetDead = 1'b1;
    #1;
    chk("targetdead_no_strike", attackSCEN, 0);
    cyc();
    gameClk = 1'b0; targetDead = 1'b0;
    chk("targetdead_alive", alive, 0);
    chk("targetdead_pos_hold", position, 31);
    chk("targetdead_hp_hold", health, 60);
    chk("targetdead_dmg", damageOut, 0);
    gameClk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_no_strike", attackSCEN, 0);
      cyc();
    end
    gameClk = 1'b0;

    // Enemy class 00: cooldown pattern, then reset during a strike.
    spawn_troop(1'b0, 2'b00);
    chk("enemy_pos0", position, 0);
    march_to(9'd479, 600);
    cyc(); cyc();
    chk("enemy_range_pos", position, 479);
    for (int t = 1; t <= 25; t++) begin
      gameClk = 1'b1;
      #1;
      chk("strike_pattern", attackSCEN, ((t % 8) == 1) ? 1 : 0);
      if ((t % 8) == 1) chk("strike_dmg", damageOut, 10);
      if (t == 25) begin
        reset = 1'b1;
        #1;
        chk("rst_mid_attack", attackSCEN, 0);
        chk("rst_mid_pos", position, 0);
        chk("rst_mid_hp", health, 0);
        chk("rst_mid_dmg", damageOut, 0);
        chk("rst_mid_alive", alive, 0);
        reset = 1'b0;
        gameClk = 1'b0;
      end else begin
        cyc();
        gameClk = 1'b0;
        cyc();
      end
    end
    cyc(); cyc();
    chk("post_rst_idle", alive, 0);

    // Enemy class 11: hits, lethal hit with targetDead, death timer.
    spawn_troop(1'b0, 2'b11);
    chk("c11_pos", position, 0);
    chk("c11_hp", health, 40);
    chk("c11_dmg", damageOut, 40);
    gameClk = 1'b1;
    cyc();
    gameClk = 1'b0;
    chk("c11_step", position, 3);
    hitIn = 1'b1; damageIn = 8'd15;
    cyc();
    chk("hit1_hp", health, 25);
    cyc();
    hitIn = 1'b0;
    chk("hit2_hp", health, 10);
    hitIn = 1'b1; damageIn = 8'd10; targetDead = 1'b1;
    cyc();
    hitIn = 1'b0; targetDead = 1'b0;
    chk("lethal_hp", health, 0);
    chk("lethal_dead", dead, 1);
    chk("lethal_alive", alive, 0);
    chk("lethal_dmg", damageOut, 0);
    hitIn = 1'b1; damageIn = 8'd5;
    cyc();
    hitIn = 1'b0;
    chk("dead_hit_ignored", health, 0);
    for (int t = 1; t <= 9; t++) begin
      gameClk = 1'b1;
      cyc();
      gameClk = 1'b0;
      cyc();
    end
    chk("dead_9_ticks", dead, 1);
    gameClk = 1'b1;
    cyc();
    gameClk = 1'b0;
    chk("dead_10_ticks", dead, 0);
    chk("dead_to_idle_alive", alive, 0);

    // Lethal hit coinciding with a strike tick.
    spawn_troop(1'b0, 2'b11);
    march_to(9'd480, 300);
    cyc(); cyc();
    gameClk = 1'b1; hitIn = 1'b1; damageIn = 8'd50;
    #1;
    chk("hit_strike_scen", attackSCEN, 1);
    chk("hit_strike_dmg", damageOut, 40);
    cyc();
    gameClk = 1'b0; hitIn = 1'b0;
    chk("hit_strike_dead", dead, 1);
    chk("hit_strike_hp", health, 0);
    chk("hit_strike_after", attackSCEN, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/troop_attacker.md
TROOP_ATTACKER -- requirements
Module: troop_attacker

Interface
REQ-001 Parameter RANGE, default 9'd32: distance from target tower edge at which the troop stops and attacks.
REQ-002 Parameter COOLDOWN, default 4'd8: gameClk ticks between successive strikes.
REQ-003 Parameter DEATH_TICKS, default 4'd10: gameClk ticks the troop stays in DEAD.
REQ-004 clk  input  1  system clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 gameClk  input  1  game tick enable, one clk cycle wide, sampled on clk.
REQ-007 spawn  input  1  request to deploy a troop, sampled in IDLE only.
REQ-008 player  input  1  1 = player troop (starts 511, moves toward 0); 0 = enemy troop (starts 0, moves toward 511).
REQ-009 unitType  input  2  troop class, latched at spawn.
REQ-010 hitIn  input  1  incoming hit strobe on this troop.
REQ-011 damageIn  input  8  damage carried by hitIn.
REQ-012 targetDead  input  1  target tower's dead flag.
REQ-013 position  output  9  current troop x-position.
REQ-014 health  output  8  current troop health.
REQ-015 damageOut  output  8  damage of this troop; connects to tower damageIn.
REQ-016 attackSCEN  output  1  one-clk strike strobe; connects to tower attackSCEN.
REQ-017 alive  output  1  high in MARCH and ATTACK.
REQ-018 dead  output  1  high in DEAD.

Function
REQ-019 States: IDLE, DEPLOY, MARCH, ATTACK, DEAD; one-hot encoding; unreachable codes return to IDLE next clk.
REQ-020 Class table (hp/dmg/speed): 00 = 100/10/1; 01 = 60/20/2; 10 = 200/5/1; 11 = 40/40/3.
REQ-021 IDLE: spawn=1 -> DEPLOY next clk; unitType and player latched; spawn ignored in all other states.
REQ-022 DEPLOY (exactly one clk): health <= class hp, damageOut <= class dmg, position <= 511 (player) or 0 (enemy), cooldown <= 0; -> MARCH.
REQ-023 MARCH: each gameClk moves position by speed toward target, saturating at 0 and 511.
REQ-024 In-range test: player troop position <= RANGE; enemy troop position >= 511-RANGE; evaluated every clk in MARCH; true -> ATTACK next clk with no further movement.
REQ-025 ATTACK: on gameClk with cooldown==0, attackSCEN=1 for exactly that one clk and cooldown <= COOLDOWN-1; on gameClk with cooldown!=0, cooldown decrements; first strike on first gameClk in ATTACK.
REQ-026 damageOut is stable at class dmg whenever attackSCEN=1; damageOut=0 in IDLE and DEAD.
REQ-027 Hits: in MARCH/ATTACK, hitIn=1 -> health <= health-damageIn saturating at 0; damageIn >= health -> DEAD next clk; hitIn ignored in IDLE, DEPLOY, DEAD.
REQ-028 Hit and strike same clk: strike still issued (attackSCEN=1), then DEAD.
REQ-029 targetDead=1 in MARCH/ATTACK -> IDLE next clk, no strike that clk, alive=0, health and position hold last values.
REQ-030 targetDead and lethal hit same clk: DEAD takes priority.
REQ-031 DEAD: tick counter cleared on entry; increments per gameClk; reaching DEATH_TICKS -> IDLE; health=0.
REQ-032 gameClk held high multiple clks is counted once per clk (no edge detection).

Reset
REQ-033 reset=1 forces, asynchronously: state IDLE, position 0, health 0, damageOut 0, attackSCEN 0, alive 0, dead 0, counters 0.
REQ-034 reset mid-strike drops attackSCEN in the same cycle; first action after release requires new spawn.

Verification
REQ-035 player=1, unitType=01, spawn, gameClk every 4 clks -> DEPLOY 1 clk, position 511, health 60, then -2 per tick, ATTACK when position <= 32.
REQ-036 In ATTACK, unitType=00, 20 ticks -> attackSCEN pulses on ticks 1, 9, 17, each 1 clk, damageOut=10.
REQ-037 unitType=11 (hp 40), hitIn with damageIn=15 twice -> health 25, 10; third hit damageIn=10 -> health 0, DEAD, dead=1 for 10 ticks, then IDLE.
REQ-038 Lethal hit coincident with strike tick -> attackSCEN=1 that clk, DEAD next clk.
REQ-039 targetDead asserted in ATTACK -> IDLE next clk, no further attackSCEN; spawn in MARCH ignored.
REQ-040 reset asserted mid-ATTACK -> all outputs 0 immediately; enemy respawn -> position 0, moves toward 511.
